// File: rtl/dm_pkg.sv
// dm_pkg -- shared definitions for the data-memory responder.
//   dm_state_e : responder FSM encoding (IDLE -> WAIT -> RESP -> IDLE)
//   dm_req_t   : request fields latched at the accept edge
//   MMIO_*     : full 16-bit addresses of the access counters (DM_MMIO_EN builds)
//   sat_inc    : saturating increment for the access counters
package dm_pkg;

  localparam int DATA_W     = 16;  // storage word and bus data width
  localparam int ADDR_BUS_W = 16;  // width of the requester address bus
  localparam int CNT_W      = 16;  // MMIO access counter width
  localparam int LAT_W      = 4;   // latency counter width, covers LATENCY 1..15

  localparam logic [ADDR_BUS_W-1:0] MMIO_RDCNT_ADDR = 16'hFFF0;
  localparam logic [ADDR_BUS_W-1:0] MMIO_WRCNT_ADDR = 16'hFFF1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic                  is_wr;
    logic [ADDR_BUS_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } dm_req_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dm_sram.sv
// dm_sram -- synchronous 1R/1W word array, 2**ADDR_W x DATA_W.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset of the read-data register only
//   we    : write mem[addr] <= wdata at this edge
//   re    : capture mem[addr] into rdata at this edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds until the next read capture
module dm_sram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // NOTE: the array has no reset branch; clearing every word would turn the
  // RAM into a flop bank. Only the read-data register is reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment in clocked logic so every flop samples
    // the pre-edge values, independent of statement order.
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves rdata_d unassigned (no latch).
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// dm_responder -- memory-side responder for CPU data-memory accesses.
// One read or write is accepted per handshake and completed LATENCY cycles
// after the accept edge with a one-cycle rdy strobe. Storage is dm_sram.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (aborts an access in flight)
//   re / we  : read / write request, held until rdy; we wins if both high
//   addr     : word address, only addr[ADDR_W-1:0] reaches storage
//   wrt_data : write data, held with we
//   busy     : high from the cycle after accept through the rdy cycle
//   rdy      : one-cycle completion strobe
//   rd_data  : read result, valid in the rdy cycle, held until the next read
// Parameters: ADDR_W (storage depth 2**ADDR_W), LATENCY (1..15).
// Optional feature macro DM_MMIO_EN: adds saturating read/write completion
// counters readable at 16'hFFF0 (reads) and 16'hFFF1 (writes); those two
// addresses then bypass storage. Without it they alias ordinary words.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_BUS_W-1:0] addr,
  input  logic [DATA_W-1:0]     wrt_data,
  output logic                  busy,
  output logic                  rdy,
  output logic [DATA_W-1:0]     rd_data
);

  // WAIT lasts LATENCY cycles: the counter runs LATENCY-1 .. 0 and the
  // access commits on the edge that leaves it at zero.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  dm_state_e         state_q, state_d;
  dm_req_t           req_q, req_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              commit;
  logic              hit_mmio;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] sram_rdata;

  // ---------------------------------------------------------------------------
  // Handshake FSM and request latch
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    lat_cnt_d = lat_cnt_q;
    commit    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (re | we) begin
          req_d.is_wr = we;
          req_d.addr  = addr;
          req_d.data  = wrt_data;
          lat_cnt_d   = LAT_LOAD;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        // The requester drops re/we on seeing rdy; the next request is
        // only considered from the following IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign rdy  = (state_q == ST_RESP);

  // ---------------------------------------------------------------------------
  // Storage. A reset coinciding with the commit edge must drop the write,
  // so the write enable is qualified with rst here (the array itself has no
  // reset). A read capture needs no gating: rst clears the read register.
  // ---------------------------------------------------------------------------
  assign mem_we = commit & req_q.is_wr & ~hit_mmio & ~rst;
  assign mem_re = commit & ~req_q.is_wr & ~hit_mmio;

  dm_sram #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (req_q.addr[ADDR_W-1:0]),
    .wdata(req_q.data),
    .rdata(sram_rdata)
  );

`ifdef DM_MMIO_EN
  // ---------------------------------------------------------------------------
  // MMIO counters. The full 16-bit address is decoded, so only FFF0/FFF1
  // hit, not their aliases. Every completed access counts, including the
  // MMIO reads themselves; a counter read returns the value before its own
  // completion is counted.
  // ---------------------------------------------------------------------------
  logic              hit_rdcnt, hit_wrcnt;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              mmio_sel_q, mmio_sel_d;    // last read came from a counter
  logic [DATA_W-1:0] mmio_data_q, mmio_data_d;  // counter value it returned

  assign hit_rdcnt = (req_q.addr == MMIO_RDCNT_ADDR);
  assign hit_wrcnt = (req_q.addr == MMIO_WRCNT_ADDR);
  assign hit_mmio  = hit_rdcnt | hit_wrcnt;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mmio_sel_d  = mmio_sel_q;
    mmio_data_d = mmio_data_q;
    if (commit) begin
      if (req_q.is_wr) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_d   = sat_inc(rd_cnt_q);
        mmio_sel_d = hit_mmio;
        if (hit_mmio) begin
          mmio_data_d = hit_rdcnt ? rd_cnt_q : wr_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      mmio_sel_q  <= 1'b0;
      mmio_data_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      mmio_sel_q  <= mmio_sel_d;
      mmio_data_q <= mmio_data_d;
    end
  end

  assign rd_data = mmio_sel_q ? mmio_data_q : sram_rdata;
`else
  assign hit_mmio = 1'b0;
  assign rd_data  = sram_rdata;

  // Upper address bits are deliberately ignored when there is no MMIO decode.
  if (ADDR_W < ADDR_BUS_W) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^req_q.addr[ADDR_BUS_W-1:ADDR_W];
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder -- scoreboard bench for dm_responder.
// Two instances share clk/rst: u_dut (LATENCY=2) and u_dut_l1 (LATENCY=1).
// The driver pushes the expected rd_data and rdy cycle for each access; the
// monitor pops and compares on every rdy it sees at the falling edge.
module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        re0, we0, busy0, rdy0;
  logic [15:0] addr0, wd0, rd0;
  logic        re1, we1, busy1, rdy1;
  logic [15:0] addr1, wd1, rd1;

  dm_responder #(.ADDR_W(12), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .re(re0), .we(we0), .addr(addr0), .wrt_data(wd0),
    .busy(busy0), .rdy(rdy0), .rd_data(rd0)
  );

  dm_responder #(.ADDR_W(12), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr1), .wrt_data(wd1),
    .busy(busy1), .rdy(rdy1), .rd_data(rd1)
  );

  typedef struct {
    logic [15:0] data;  // rd_data required in the rdy cycle
    int          cyc;   // cycle count at which rdy is required
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] last_rd [2];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, want, cycle);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      re0 = r; we0 = w; addr0 = a; wd0 = d;
    end else begin
      re1 = r; we1 = w; addr1 = a; wd1 = d;
    end
  endtask

  // Monitor: every rdy must match the oldest outstanding expectation.
  task automatic mon(input int sel);
    exp_t        e;
    logic [15:0] rd;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_rdy dut%0d: got rdy=1, required rdy=0 (cycle %0d)", sel, cycle);
      return;
    end
    if (sel == 0) begin
      e  = q0.pop_front();
      rd = rd0;
    end else begin
      e  = q1.pop_front();
      rd = rd1;
    end
    check($sformatf("dut%0d_rd_data", sel), {16'h0, rd}, {16'h0, e.data});
    check($sformatf("dut%0d_rdy_cycle", sel), cycle, e.cyc);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rdy0 === 1'b1) mon(0);
      if (rdy1 === 1'b1) mon(1);
    end
  end

  // One access, called and returning at a falling edge with the DUT idle.
  // mode 0: normal; 1: reset in first WAIT cycle; 2: reset on commit edge;
  // 3: change addr/wrt_data right after accept.
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] want_rd, input int mode);
    exp_t e;
    int   lat;
    bit   seen;
    lat = (sel == 0) ? 2 : 1;
    drive(sel, r, w, a, d);
    if (mode == 1 || mode == 2) begin
      repeat (mode) @(negedge clk);
      rst = 1'b1;
      drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      check($sformatf("dut%0d_busy_after_abort", sel), (sel == 0) ? busy0 : busy1, 0);
      check($sformatf("dut%0d_rdy_after_abort", sel), (sel == 0) ? rdy0 : rdy1, 0);
      rst = 1'b0;
      last_rd = '{16'h0, 16'h0};
      return;
    end
    e.data = (r & ~w) ? want_rd : last_rd[sel];
    e.cyc  = cycle + 1 + lat;
    last_rd[sel] = e.data;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    @(negedge clk);
    check($sformatf("dut%0d_busy_after_accept", sel), (sel == 0) ? busy0 : busy1, 1);
    if (mode == 3) drive(sel, r, w, 16'h0009, 16'h0000);
    seen = (sel == 0) ? rdy0 : rdy1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? rdy0 : rdy1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d_rdy_timeout: got no rdy, required rdy within 40 cycles", sel);
    end
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check("reset_busy0", busy0, 0);
    check("reset_rdy0", rdy0, 0);
    check("reset_rd_data0", rd0, 0);
    check("reset_busy1", busy1, 0);
    check("reset_rd_data1", rd1, 0);
    rst = 1'b0;
    last_rd = '{16'h0, 16'h0};
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd = '{16'h0, 16'h0};
    @(negedge clk);
    do_reset();

    // Basic write then read-back, LATENCY=2.
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 0);
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 0);

    // LATENCY=1 back-to-back write then read of the same word.
    access(1, 1'b0, 1'b1, 16'h0003, 16'h1234, 16'h0, 0);
    access(1, 1'b1, 1'b0, 16'h0003, 16'h0, 16'h1234, 0);

    // Reset in WAIT, and reset on the commit edge: old data survives.
    access(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0, 0);
    access(0, 1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'h0, 1);
    check("rd_data0_after_abort", rd0, 0);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h5555, 0);
    access(0, 1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'h0, 2);
    access(0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h5555, 0);

    // re and we together: the write wins.
    access(0, 1'b1, 1'b1, 16'h0007, 16'h00FF, 16'h0, 0);
    access(0, 1'b1, 1'b0, 16'h0007, 16'h0, 16'h00FF, 0);

    // Address wrap, and request changes ignored once accepted.
    access(0, 1'b0, 1'b1, 16'h0009, 16'h9999, 16'h0, 0);
    access(0, 1'b0, 1'b1, 16'h1005, 16'h7777, 16'h0, 3);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0, 16'h7777, 0);
    access(0, 1'b1, 1'b0, 16'h0009, 16'h0, 16'h9999, 0);
    access(0, 1'b1, 1'b0, 16'hF005, 16'h0, 16'h7777, 0);

    // MMIO counters (or plain aliases of words 0xFF0/0xFF1 without them).
    do_reset();
    access(0, 1'b0, 1'b1, 16'h0FF0, 16'hA0A0, 16'h0, 0);
    access(0, 1'b0, 1'b1, 16'h0FF1, 16'hB1B1, 16'h0, 0);
    access(0, 1'b0, 1'b1, 16'h0030, 16'h3333, 16'h0, 0);
    access(0, 1'b1, 1'b0, 16'h0FF0, 16'h0, 16'hA0A0, 0);
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h3333, 0);
`ifdef DM_MMIO_EN
    access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, 16'h0002, 0);
    access(0, 1'b1, 1'b0, 16'hFFF1, 16'h0, 16'h0003, 0);
    access(0, 1'b0, 1'b1, 16'hFFF0, 16'hDEAD, 16'h0, 0);
    access(0, 1'b1, 1'b0, 16'h0FF0, 16'h0, 16'hA0A0, 0);
    access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, 16'h0005, 0);
`else
    access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, 16'hA0A0, 0);
    access(0, 1'b1, 1'b0, 16'hFFF1, 16'h0, 16'hB1B1, 0);
    access(0, 1'b0, 1'b1, 16'hFFF0, 16'hDEAD, 16'h0, 0);
    access(0, 1'b1, 1'b0, 16'h0FF0, 16'h0, 16'hDEAD, 0);
    access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, 16'hDEAD, 0);
`endif

    repeat (3) @(negedge clk);
    check("dut0_outstanding", q0.size(), 0);
    check("dut1_outstanding", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
